ccff_bitstream_loader: RTL and testbench

- Writer end of the configuration-chain (ccff) protocol. The fle/ble6 tiles are shift-register receivers with a ccff_head input and a ccff_tail output.
- Accepts bitstream words from a host over a valid/ready stream and serializes them LSB-first onto ccff_head.
- Produces a shift-enable that drives the chain's clock gate, so the chain advances only on cycles where the loader presents a valid bit.
- Optional second pass reads the chain back through ccff_tail and counts mismatches against the re-sent bitstream.

---
 rtl/ccff_bitstream_loader.sv | 191 +++++++++++++++++++
 tb/tb_ccff_bitstream_loader.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain writer: serializes host words LSB-first onto ccff_head with a
// matching shift enable, and optionally reads the chain back to count mismatches.
module ccff_bitstream_loader #(
    parameter int CHAIN_LEN = 70,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              verify,
    input  logic              s_valid,
    input  logic [WORD_W-1:0] s_data,
    output logic              s_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              mismatch,
    output logic [15:0]       mismatch_cnt,
    output logic [1:0]        o_dbg_state
);

    localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int LAST_BITS = ((CHAIN_LEN % WORD_W) == 0) ? WORD_W : (CHAIN_LEN % WORD_W);
    localparam int BCW       = $clog2(CHAIN_LEN + 1);
    localparam int SCW       = $clog2(WORD_W + 1);
    localparam int WCW       = $clog2(NWORDS + 1);

    localparam logic [BCW-1:0] BIT_LAST  = BCW'(CHAIN_LEN - 1);
    localparam logic [SCW-1:0] CNT_FULL  = SCW'(WORD_W);
    localparam logic [SCW-1:0] CNT_LAST  = SCW'(LAST_BITS);
    localparam logic [WCW-1:0] WORDS_ALL = WCW'(NWORDS);
    localparam logic [WCW-1:0] WORDS_M1  = WCW'(NWORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS1 = 2'd1,
        ST_PASS2 = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_verify;
    logic [WORD_W-1:0]   r_hold;
    logic [SCW-1:0]      r_hold_cnt;
    logic                r_hold_vld;
    logic [WORD_W-1:0]   r_shift;
    logic [SCW-1:0]      r_shift_cnt;
    logic [WCW-1:0]      r_words;
    logic [BCW-1:0]      r_bit_cnt;
    logic                r_head;
    logic                r_shift_en;
    logic                r_mismatch;
    logic [15:0]         r_mismatch_cnt;

    logic                w_busy;
    logic                w_start_ok;
    logic                w_pass_start;
    logic                w_pass_end;
    logic                w_accept;
    logic                w_emit;
    logic                w_reload;
    logic [SCW-1:0]      w_in_cnt;

    always_ff @(posedge prog_clk) begin
        if (!pReset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_busy       = 1'b0;
        w_start_ok   = 1'b0;
        w_pass_start = 1'b0;
        w_pass_end   = r_shift_en && (r_bit_cnt == BIT_LAST);
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_start_ok   = 1'b1;
                    w_pass_start = 1'b1;
                    w_state_nxt  = ST_PASS1;
                end
            end
            ST_PASS1: begin
                w_busy = 1'b1;
                if (w_pass_end) begin
                    w_pass_start = r_verify;
                    w_state_nxt  = r_verify ? ST_PASS2 : ST_DONE;
                end
            end
            ST_PASS2: begin
                w_busy = 1'b1;
                if (w_pass_end) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Handshake: a word transfers on any edge where s_valid & s_ready; s_data is
    // ignored otherwise. s_ready drops once the pass has all of its words.
    assign s_ready  = w_busy && !r_hold_vld && (r_words != WORDS_ALL);
    assign w_accept = s_valid && s_ready;
    assign w_in_cnt = (r_words == WORDS_M1) ? CNT_LAST : CNT_FULL;
    assign w_emit   = w_busy && (r_shift_cnt != '0);
    // Refill in the same cycle the last bit leaves, so a steady stream has no gaps.
    assign w_reload = w_busy && (r_shift_cnt <= SCW'(1));

    always_ff @(posedge prog_clk) begin
        if (!pReset) begin
            r_verify       <= 1'b0;
            r_hold         <= '0;
            r_hold_cnt     <= '0;
            r_hold_vld     <= 1'b0;
            r_shift        <= '0;
            r_shift_cnt    <= '0;
            r_words        <= '0;
            r_bit_cnt      <= '0;
            r_head         <= 1'b0;
            r_shift_en     <= 1'b0;
            r_mismatch     <= 1'b0;
            r_mismatch_cnt <= '0;
        end else begin
            if (w_start_ok) begin
                r_verify <= verify;
            end

            if (w_pass_start) begin
                r_words <= '0;
            end else if (w_accept) begin
                r_words <= r_words + 1'b1;
            end

            if (w_pass_start || w_pass_end) begin
                r_bit_cnt <= '0;
            end else if (r_shift_en) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end

            r_shift_en <= w_emit;
            if (w_emit) begin
                r_head      <= r_shift[0];
                r_shift     <= r_shift >> 1;
                r_shift_cnt <= r_shift_cnt - 1'b1;
            end

            if (w_reload) begin
                if (r_hold_vld) begin
                    r_shift     <= r_hold;
                    r_shift_cnt <= r_hold_cnt;
                    r_hold_vld  <= 1'b0;
                end else if (w_accept) begin
                    r_shift     <= s_data;
                    r_shift_cnt <= w_in_cnt;
                end
            end else if (w_accept) begin
                r_hold     <= s_data;
                r_hold_cnt <= w_in_cnt;
                r_hold_vld <= 1'b1;
            end

            // During readback the tail shows the first-pass bit with the same index.
            if (w_start_ok) begin
                r_mismatch     <= 1'b0;
                r_mismatch_cnt <= '0;
            end else if ((r_state == ST_PASS2) && r_shift_en && (ccff_tail != r_head)) begin
                r_mismatch <= 1'b1;
                if (r_mismatch_cnt != 16'hFFFF) begin
                    r_mismatch_cnt <= r_mismatch_cnt + 16'd1;
                end
            end
        end
    end

    assign ccff_head     = r_head;
    assign ccff_shift_en = r_shift_en;
    assign busy          = w_busy;
    assign done          = (r_state == ST_DONE);
    assign mismatch      = r_mismatch;
    assign mismatch_cnt  = r_mismatch_cnt;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: 10-FF shift-gated chain model, host driver and a
// bit scoreboard checked on every shift cycle.
module tb_ccff_bitstream_loader;

    localparam int CL = 10;
    localparam int WW = 8;

    logic          prog_clk = 1'b0;
    logic          pReset;
    logic          start;
    logic          verify;
    logic          s_valid;
    logic [WW-1:0] s_data;
    logic          s_ready;
    logic          ccff_head;
    logic          ccff_shift_en;
    logic          ccff_tail;
    logic          busy;
    logic          done;
    logic          mismatch;
    logic [15:0]   mismatch_cnt;
    logic [1:0]    o_dbg_state;

    logic [CL-1:0] chain = '0;
    logic          tail_zero;
    logic          all_sent;
    logic [0:0]    exp_q[$];
    int            cyc = 0;
    int            errors = 0;
    int            checks = 0;

    ccff_bitstream_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
        .prog_clk      (prog_clk),
        .pReset        (pReset),
        .start         (start),
        .verify        (verify),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_ready       (s_ready),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .ccff_tail     (ccff_tail),
        .busy          (busy),
        .done          (done),
        .mismatch      (mismatch),
        .mismatch_cnt  (mismatch_cnt),
        .o_dbg_state   (o_dbg_state)
    );

    // Clock, cycle counter and the gated chain model.
    always #5 prog_clk = ~prog_clk;

    always @(posedge prog_clk) begin
        cyc <= cyc + 1;
        if (ccff_shift_en) begin
            chain <= {chain[CL-2:0], ccff_head};
        end
    end

    assign ccff_tail = tail_zero ? 1'b0 : chain[CL-1];

    // Driver: present one word, wait for acceptance, queue its shifted bits.
    task automatic send_word(input logic [WW-1:0] w, input int nbits);
        int t;
        t = 0;
        s_valid = 1'b1;
        s_data  = w;
        @(negedge prog_clk);
        while (!s_ready && t < 100) begin
            t++;
            @(negedge prog_clk);
        end
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_word: s_ready=%b, required 1 within 100 cycles", s_ready);
            s_valid = 1'b0;
            return;
        end
        for (int b = 0; b < nbits; b++) begin
            exp_q.push_back(w[b]);
        end
        @(posedge prog_clk);
        #1;
    endtask

    task automatic host(input logic v, input int gap, input logic poke);
        for (int p = 0; p < (v ? 2 : 1); p++) begin
            send_word(8'hA5, WW);
            if (gap > 0) begin
                s_valid = 1'b0;
                repeat (gap) @(posedge prog_clk);
                #1;
            end
            send_word(8'h03, CL - WW);
        end
        all_sent = 1'b1;
        s_valid  = 1'b0;
        s_data   = 8'($urandom_range(0, 255));
        if (poke) begin
            start  = 1'b1;
            verify = 1'b1;
            @(posedge prog_clk);
            #1;
            start  = 1'b0;
            verify = 1'b0;
        end
    endtask

    // Scoreboard: pop one expected bit per shift cycle, record timing of shifts and done.
    task automatic monitor(input int budget, input int stop_shifts,
                           output int n_shift, output int first_c, output int last_c,
                           output int done_c, output int n_done, output int sready_late);
        logic [0:0] exp_b;
        n_shift = 0; first_c = -1; last_c = -1; done_c = -1; n_done = 0; sready_late = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge prog_clk);
            if (all_sent && s_ready) sready_late++;
            if (ccff_shift_en) begin
                n_shift++;
                if (first_c < 0) first_c = cyc;
                last_c = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL shift_bit: extra shift at cycle %0d, head=%b, no bit expected", cyc, ccff_head);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (ccff_head !== exp_b) begin
                        errors++;
                        $display("FAIL shift_bit: shift %0d head=%b, required %b", n_shift, ccff_head, exp_b);
                    end
                end
                if (stop_shifts > 0 && n_shift == stop_shifts) return;
            end
            if (done === 1'b1) begin
                n_done++;
                done_c = cyc;
            end
            if (n_done > 0 && cyc >= done_c + 3) return;
        end
        checks++;
        errors++;
        $display("FAIL monitor_timeout: shifts=%0d done_pulses=%0d after %0d cycles", n_shift, n_done, budget);
    endtask

    task automatic run_load(input logic v, input int gap, input logic poke,
                            output int n_shift, output int first_c, output int last_c,
                            output int done_c, output int n_done, output int start_c,
                            output int sready_late, output logic mm0, output logic [15:0] cnt0);
        exp_q.delete();
        all_sent = 1'b0;
        @(posedge prog_clk);
        #1;
        start  = 1'b1;
        verify = v;
        @(posedge prog_clk);
        #1;
        start   = 1'b0;
        verify  = 1'($urandom_range(0, 1));
        start_c = cyc;
        mm0     = mismatch;
        cnt0    = mismatch_cnt;
        fork
            host(v, gap, poke);
            monitor(200, 0, n_shift, first_c, last_c, done_c, n_done, sready_late);
        join
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_bits: %0d bits never shifted, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        pReset = 1'b0; start = 1'b0; verify = 1'b0; s_valid = 1'b0; s_data = '0;
        tail_zero = 1'b0; all_sent = 1'b0;
        repeat (3) @(posedge prog_clk);
        #1;
        checks++;
        if ({busy, done, s_ready, ccff_shift_en, ccff_head, mismatch} !== 6'b0 || mismatch_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b rdy=%b sen=%b head=%b mm=%b cnt=%0d, required all 0",
                     busy, done, s_ready, ccff_shift_en, ccff_head, mismatch, mismatch_cnt);
        end
        pReset = 1'b1;
        s_valid = 1'b1;
        s_data = 8'($urandom_range(0, 255));
        repeat (3) @(posedge prog_clk);
        #1;
        s_valid = 1'b0;
        checks++;
        if (o_dbg_state !== 2'd0 || busy !== 1'b0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: state=%0d busy=%b rdy=%b, required 0/0/0", o_dbg_state, busy, s_ready);
        end
    endtask

    task automatic test_basic(input logic poke, input string tag);
        int ns, fc, lc, dc, nd, sc, sl;
        logic mm0;
        logic [15:0] c0;
        run_load(1'b0, 0, poke, ns, fc, lc, dc, nd, sc, sl, mm0, c0);
        checks++;
        if (ns !== CL) begin errors++; $display("FAIL %s_shifts: %0d, required %0d", tag, ns, CL); end
        checks++;
        if (nd !== 1) begin errors++; $display("FAIL %s_done_pulses: %0d, required 1", tag, nd); end
        checks++;
        if (dc - lc !== 1) begin errors++; $display("FAIL %s_done_after_last: %0d cycles, required 1", tag, dc - lc); end
        checks++;
        if (lc - fc + 1 !== CL) begin errors++; $display("FAIL %s_bubbles: span %0d, required %0d", tag, lc - fc + 1, CL); end
        checks++;
        if (dc - sc !== CL + 2) begin errors++; $display("FAIL %s_done_latency: %0d, required %0d", tag, dc - sc, CL + 2); end
        checks++;
        if (sl !== 0) begin errors++; $display("FAIL %s_sready_late: high %0d cycles, required 0", tag, sl); end
        checks++;
        if (mismatch !== 1'b0 || mismatch_cnt !== 16'd0) begin
            errors++;
            $display("FAIL %s_mismatch: mm=%b cnt=%0d, required 0/0", tag, mismatch, mismatch_cnt);
        end
    endtask

    task automatic test_verify();
        int ns, fc, lc, dc, nd, sc, sl;
        logic mm0;
        logic [15:0] c0;
        tail_zero = 1'b0;
        run_load(1'b1, 0, 1'b0, ns, fc, lc, dc, nd, sc, sl, mm0, c0);
        checks++;
        if (ns !== 2 * CL) begin errors++; $display("FAIL verify_shifts: %0d, required %0d", ns, 2 * CL); end
        checks++;
        if (nd !== 1 || dc - sc !== 2 * CL + 4) begin
            errors++;
            $display("FAIL verify_done: pulses=%0d latency=%0d, required 1/%0d", nd, dc - sc, 2 * CL + 4);
        end
        checks++;
        if (mismatch !== 1'b0 || mismatch_cnt !== 16'd0) begin
            errors++;
            $display("FAIL verify_clean: mm=%b cnt=%0d, required 0/0", mismatch, mismatch_cnt);
        end
    endtask

    task automatic test_mismatch();
        int ns, fc, lc, dc, nd, sc, sl;
        logic mm0;
        logic [15:0] c0;
        tail_zero = 1'b1;
        run_load(1'b1, 0, 1'b0, ns, fc, lc, dc, nd, sc, sl, mm0, c0);
        tail_zero = 1'b0;
        checks++;
        if (mismatch !== 1'b1 || mismatch_cnt !== 16'd6) begin
            errors++;
            $display("FAIL mismatch_count: mm=%b cnt=%0d, required 1/6", mismatch, mismatch_cnt);
        end
        run_load(1'b0, 0, 1'b0, ns, fc, lc, dc, nd, sc, sl, mm0, c0);
        checks++;
        if (mm0 !== 1'b0 || c0 !== 16'd0) begin
            errors++;
            $display("FAIL mismatch_clear: mm=%b cnt=%0d after start, required 0/0", mm0, c0);
        end
    endtask

    task automatic test_starve();
        int ns, fc, lc, dc, nd, sc, sl;
        logic mm0;
        logic [15:0] c0;
        // Hold s_valid low long enough that the shifter drains and idles 5 cycles.
        run_load(1'b0, WW + 4, 1'b0, ns, fc, lc, dc, nd, sc, sl, mm0, c0);
        checks++;
        if (ns !== CL) begin errors++; $display("FAIL starve_shifts: %0d, required %0d", ns, CL); end
        checks++;
        if (lc - fc + 1 - ns !== 5) begin errors++; $display("FAIL starve_bubbles: %0d, required 5", lc - fc + 1 - ns); end
        checks++;
        if (nd !== 1 || dc - sc !== CL + 7) begin
            errors++;
            $display("FAIL starve_done: pulses=%0d latency=%0d, required 1/%0d", nd, dc - sc, CL + 7);
        end
    endtask

    task automatic test_reset_mid();
        int ns, fc, lc, dc, nd, sl, n_done, n_sen;
        exp_q.delete();
        all_sent = 1'b0;
        @(posedge prog_clk);
        #1;
        start = 1'b1;
        verify = 1'b0;
        @(posedge prog_clk);
        #1;
        start = 1'b0;
        fork
            host(1'b0, 0, 1'b0);
            monitor(50, 4, ns, fc, lc, dc, nd, sl);
        join
        pReset = 1'b0;
        @(posedge prog_clk);
        #1;
        pReset = 1'b1;
        exp_q.delete();
        checks++;
        if ({busy, s_ready, ccff_shift_en, done} !== 4'b0) begin
            errors++;
            $display("FAIL reset_mid_outputs: busy=%b rdy=%b sen=%b done=%b, required 0000",
                     busy, s_ready, ccff_shift_en, done);
        end
        n_done = 0;
        n_sen  = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge prog_clk);
            if (done) n_done++;
            if (ccff_shift_en) n_sen++;
        end
        checks++;
        if (n_done !== 0 || n_sen !== 0) begin
            errors++;
            $display("FAIL reset_mid_quiet: done=%0d shifts=%0d after abort, required 0/0", n_done, n_sen);
        end
    endtask

    initial begin
        test_reset();
        test_basic(1'b0, "basic");
        test_verify();
        test_mismatch();
        test_starve();
        test_reset_mid();
        test_basic(1'b0, "after_reset");
        test_basic(1'b1, "start_ignored");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
